// File: rtl/fifo_multi_ch_tick_w_ctrl_signals_pkg.sv
// Shared definitions for the multi-channel tick-written FIFO bank:
// operating modes, default sizes and helpers for pointer and count widths.
package fifo_multi_ch_tick_w_ctrl_signals_pkg;

  typedef enum logic {
    MODE_WORK = 1'b0,
    MODE_LOAD = 1'b1
  } mode_e;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_DEPTH      = 8;

  typedef logic [DEF_DATA_WIDTH-1:0] data_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_multi_ch_tick_w_ctrl_signals_mem.sv
// Storage for one channel: synchronous write port, asynchronous read port
// so the head entry is visible without a read-latency cycle.
module fifo_ch_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [PTR_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_multi_ch_tick_w_ctrl_signals.sv
// Bank of NUM_CH FIFOs on one clock. Producers write on an internal periodic
// tick; the consumer reads whenever the derived block enable is high.
module fifo_multi_ch_tick_w_ctrl_signals
  import fifo_multi_ch_tick_w_ctrl_signals_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DIV_RATIO  = 4,
  parameter int unsigned AF_MARGIN  = 1,
  localparam int unsigned PTR_W     = ptr_width(DEPTH),
  localparam int unsigned CNT_W     = cnt_width(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         unit_en,
  input  logic                         mode,
  input  logic                         out_q_wr_ready,
  input  logic [NUM_CH-1:0]            flush,
  input  logic [NUM_CH-1:0]            wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_CH-1:0]            rd_req,
  output logic                         blk_en,
  output logic                         wr_tick,
  output logic [NUM_CH-1:0]            wr_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_CH-1:0]            fifo_empty,
  output logic [NUM_CH*CNT_W-1:0]      fifo_count,
  output logic [NUM_CH-1:0]            overflow_err
);

  localparam int unsigned TICK_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV_RATIO - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_AF    = CNT_W'(DEPTH - AF_MARGIN);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic              work;
  logic [NUM_CH-1:0] halt, wr_fire, rd_fire;

  always_comb begin
    tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) tick_q <= '0;
    else     tick_q <= tick_d;
  end

  // With DIV_RATIO=1 the counter sits at 0 == TICK_LAST, so the tick is constant.
  assign wr_tick = (tick_q == TICK_LAST);
  assign work    = (mode == MODE_WORK);
  assign blk_en  = work & unit_en & ~|halt & out_q_wr_ready;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d, wr_ready_q;
    logic                  full;
    logic [DATA_WIDTH-1:0] head;

    assign full            = (count_q == CNT_FULL);
    assign fifo_empty[gi]  = (count_q == '0);
    assign halt[gi]        = work & rd_req[gi] & fifo_empty[gi];
    assign wr_fire[gi]     = wr_tick & work & wr_en[gi] & ~full;
    assign rd_fire[gi]     = blk_en & rd_req[gi] & ~fifo_empty[gi];

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (flush[gi]) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        ovf_d    = 1'b0;
      end else begin
        if (wr_fire[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_fire[gi]) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_fire[gi], rd_fire[gi]})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
        if (wr_tick & work & wr_en[gi] & full) ovf_d = 1'b1;
      end
    end

    // Registered from the next count so it is already valid at the next tick;
    // a flush drives count_d to 0, which also forces ready high.
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        ovf_q      <= 1'b0;
        wr_ready_q <= 1'b1;
      end else begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        count_q    <= count_d;
        ovf_q      <= ovf_d;
        wr_ready_q <= (count_d < CNT_AF);
      end
    end

    fifo_ch_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_mem (
      .clk     (clk),
      .we_i    (wr_fire[gi] & ~flush[gi]),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data[gi*DATA_WIDTH +: DATA_WIDTH]),
      .raddr_i (rd_ptr_q),
      .rdata_o (head)
    );

    assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = head;
    assign fifo_count[gi*CNT_W +: CNT_W]        = count_q;
    assign overflow_err[gi]                     = ovf_q;
    assign wr_ready[gi]                         = wr_ready_q;
  end

endmodule

// File: tb/tb_fifo_multi_ch_tick_w_ctrl_signals.sv
// Directed bench for the tick-written FIFO bank with default parameters.
module tb_fifo_multi_ch_tick_w_ctrl_signals;
  import fifo_multi_ch_tick_w_ctrl_signals_pkg::*;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           unit_en;
  logic           mode;
  logic           out_q_wr_ready;
  logic [NC-1:0]  flush;
  logic [NC-1:0]  wr_en;
  logic [NC*DW-1:0] wr_data;
  logic [NC-1:0]  rd_req;
  logic           blk_en;
  logic           wr_tick;
  logic [NC-1:0]  wr_ready;
  logic [NC*DW-1:0] rd_data;
  logic [NC-1:0]  fifo_empty;
  logic [NC*CW-1:0] fifo_count;
  logic [NC-1:0]  overflow_err;

  int tests = 0;
  int fails = 0;

  fifo_multi_ch_tick_w_ctrl_signals dut (
    .clk            (clk),
    .rst            (rst),
    .unit_en        (unit_en),
    .mode           (mode),
    .out_q_wr_ready (out_q_wr_ready),
    .flush          (flush),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .rd_req         (rd_req),
    .blk_en         (blk_en),
    .wr_tick        (wr_tick),
    .wr_ready       (wr_ready),
    .rd_data        (rd_data),
    .fifo_empty     (fifo_empty),
    .fifo_count     (fifo_count),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] cnt(input int ch);
    return fifo_count[ch*CW +: CW];
  endfunction

  function automatic logic [DW-1:0] rdat(input int ch);
    return rd_data[ch*DW +: DW];
  endfunction

  task automatic wait_tick();
    int n = 0;
    while (wr_tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (wr_tick !== 1'b1) begin
      tests++; fails++;
      $display("FAIL wait_tick: wr_tick=%b required 1 within 20 cycles", wr_tick);
    end
  endtask

  task automatic test_reset();
    logic exp_tick;
    rst = 1'b1; unit_en = 1'b0; mode = MODE_WORK; out_q_wr_ready = 1'b0;
    flush = '0; wr_en = '0; wr_data = '0; rd_req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++;
    if (fifo_empty !== 4'hF || wr_ready !== 4'hF || fifo_count !== '0 || overflow_err !== '0) begin
      fails++;
      $display("FAIL reset_state: empty=%h ready=%h count=%h ovf=%h required F F 0 0",
               fifo_empty, wr_ready, fifo_count, overflow_err);
    end
    for (int c = 1; c <= 12; c++) begin
      exp_tick = (c % 4 == 0);
      tests++;
      if (wr_tick !== exp_tick) begin
        fails++;
        $display("FAIL tick_cycle%0d: wr_tick=%b required %b", c, wr_tick, exp_tick);
      end
      $display("[TB] reset idle cycle %0d wr_tick=%b", c, wr_tick);
      @(negedge clk);
    end
    tests++;
    if (fifo_empty !== 4'hF || fifo_count !== '0) begin
      fails++;
      $display("FAIL idle_state: empty=%h count=%h required F 0", fifo_empty, fifo_count);
    end
  endtask

  task automatic test_fill_overflow();
    logic [CW-1:0] exp_cnt;
    wr_en = 4'b0001;
    for (int k = 0; k < 9; k++) begin
      wait_tick();
      wr_data[0 +: DW] = 32'h10 + k;
      @(negedge clk);
      exp_cnt = (k < 8) ? CW'(k + 1) : CW'(8);
      tests++;
      if (cnt(0) !== exp_cnt) begin
        fails++;
        $display("FAIL fill_count_t%0d: count0=%0d required %0d", k, cnt(0), exp_cnt);
      end
      tests++;
      if (wr_ready[0] !== (exp_cnt < 7)) begin
        fails++;
        $display("FAIL fill_ready_t%0d: wr_ready0=%b required %b", k, wr_ready[0], exp_cnt < 7);
      end
      tests++;
      if (overflow_err[0] !== (k == 8)) begin
        fails++;
        $display("FAIL fill_ovf_t%0d: ovf0=%b required %b", k, overflow_err[0], k == 8);
      end
      $display("[TB] fill tick %0d count0=%0d ready0=%b ovf0=%b", k, cnt(0), wr_ready[0], overflow_err[0]);
    end
    wr_en = '0;
    tests++;
    if (rdat(0) !== 32'h10) begin
      fails++;
      $display("FAIL fill_head: rd_data0=%h required 00000010", rdat(0));
    end
  endtask

  task automatic test_read_halt();
    wait_tick();
    wr_en = 4'b0010;
    wr_data[1*DW +: DW] = 32'hA5;
    @(negedge clk);
    wr_en = '0;
    rd_req = 4'b0010; unit_en = 1'b1; out_q_wr_ready = 1'b1;
    #1;
    tests++;
    if (blk_en !== 1'b1 || rdat(1) !== 32'hA5) begin
      fails++;
      $display("FAIL read_fire: blk_en=%b rd_data1=%h required 1 000000a5", blk_en, rdat(1));
    end
    @(negedge clk);
    tests++;
    if (cnt(1) !== 4'd0 || blk_en !== 1'b0) begin
      fails++;
      $display("FAIL read_halt: count1=%0d blk_en=%b required 0 0", cnt(1), blk_en);
    end
    $display("[TB] read ch1 then halt count1=%0d blk_en=%b", cnt(1), blk_en);
    rd_req = '0;
  endtask

  task automatic test_simul_rw();
    for (int k = 0; k < 3; k++) begin
      wait_tick();
      wr_en = 4'b0100;
      wr_data[2*DW +: DW] = 32'h20 + k;
      @(negedge clk);
      wr_en = '0;
    end
    tests++;
    if (cnt(2) !== 4'd3) begin
      fails++;
      $display("FAIL simul_pre: count2=%0d required 3", cnt(2));
    end
    wait_tick();
    wr_en = 4'b0100;
    wr_data[2*DW +: DW] = 32'h23;
    rd_req = 4'b0100;
    #1;
    tests++;
    if (blk_en !== 1'b1 || rdat(2) !== 32'h20) begin
      fails++;
      $display("FAIL simul_head: blk_en=%b rd_data2=%h required 1 00000020", blk_en, rdat(2));
    end
    @(negedge clk);
    wr_en = '0;
    tests++;
    if (cnt(2) !== 4'd3) begin
      fails++;
      $display("FAIL simul_count: count2=%0d required 3", cnt(2));
    end
    for (int j = 0; j < 3; j++) begin
      tests++;
      if (rdat(2) !== 32'h21 + j) begin
        fails++;
        $display("FAIL simul_order%0d: rd_data2=%h required %h", j, rdat(2), 32'h21 + j);
      end
      $display("[TB] drain ch2 entry %0d rd_data2=%h", j, rdat(2));
      @(negedge clk);
    end
    tests++;
    if (cnt(2) !== 4'd0) begin
      fails++;
      $display("FAIL simul_drained: count2=%0d required 0", cnt(2));
    end
    rd_req = '0;
  endtask

  task automatic test_flush();
    tests++;
    if (overflow_err[0] !== 1'b1 || cnt(0) !== 4'd8) begin
      fails++;
      $display("FAIL flush_pre: ovf0=%b count0=%0d required 1 8", overflow_err[0], cnt(0));
    end
    wait_tick();
    flush = 4'b0001;
    wr_en = 4'b1000;
    wr_data[3*DW +: DW] = 32'h33;
    @(negedge clk);
    flush = '0; wr_en = '0;
    tests++;
    if (cnt(0) !== 4'd0 || overflow_err[0] !== 1'b0 || wr_ready[0] !== 1'b1) begin
      fails++;
      $display("FAIL flush_ch0: count0=%0d ovf0=%b ready0=%b required 0 0 1",
               cnt(0), overflow_err[0], wr_ready[0]);
    end
    tests++;
    if (cnt(3) !== 4'd1 || fifo_empty !== 4'b0111) begin
      fails++;
      $display("FAIL flush_ch3: count3=%0d empty=%b required 1 0111", cnt(3), fifo_empty);
    end
    $display("[TB] flush ch0 count0=%0d count3=%0d", cnt(0), cnt(3));
  endtask

  task automatic test_load_mode();
    mode = MODE_LOAD;
    wr_en = 4'hF;
    wr_data = {4{32'hDEAD_BEEF}};
    for (int k = 0; k < 3; k++) begin
      wait_tick();
      #1;
      tests++;
      if (blk_en !== 1'b0) begin
        fails++;
        $display("FAIL load_blk_t%0d: blk_en=%b required 0", k, blk_en);
      end
      @(negedge clk);
      $display("[TB] load tick %0d counts=%h", k, fifo_count);
    end
    tests++;
    if (fifo_count !== 16'h1000 || overflow_err !== '0) begin
      fails++;
      $display("FAIL load_hold: count=%h ovf=%b required 1000 0000", fifo_count, overflow_err);
    end
    wr_en = '0;
    mode = MODE_WORK;
    rd_req = 4'b1000;
    #1;
    tests++;
    if (blk_en !== 1'b1 || rdat(3) !== 32'h33) begin
      fails++;
      $display("FAIL load_intact: blk_en=%b rd_data3=%h required 1 00000033", blk_en, rdat(3));
    end
    @(negedge clk);
    tests++;
    if (cnt(3) !== 4'd0) begin
      fails++;
      $display("FAIL load_read: count3=%0d required 0", cnt(3));
    end
    $display("[TB] work read ch3 count3=%0d", cnt(3));
    rd_req = '0;
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_read_halt();
    test_simul_rw();
    test_flush();
    test_load_mode();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_multi_ch_tick_w_ctrl_signals.md
Name: fifo_multi_ch_tick_w_ctrl_signals

Overview:
Parametrised bank of NUM_CH independent FIFOs, all on one clock. Producers write only on a periodic write tick generated internally every DIV_RATIO cycles; this replaces the divided slow clock. The consumer reads on any enabled cycle. The block derives the fast-side block enable from per-channel read halts and downstream readiness. It adds programmable almost-full backpressure, per-channel flush, occupancy reporting and sticky overflow detection.

Parameters:
DATA_WIDTH, 32, width of one FIFO entry
DEPTH, 8, entries per channel; must be a power of two, ≥2
NUM_CH, 4, number of channels
DIV_RATIO, 4, write-tick period in clk cycles; 1 gives a tick every cycle
AF_MARGIN, 1, wr_ready drops once occupancy ≥ DEPTH-AF_MARGIN; range 0..DEPTH-1

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
unit_en  in  1  unit enable
mode  in  1  MODE_WORK or MODE_LOAD (shared package constants)
out_q_wr_ready  in  1  downstream queue can accept
flush  in  NUM_CH  per-channel synchronous clear
wr_en  in  NUM_CH  producer write request, sampled on tick cycles only
wr_data  in  NUM_CH x DATA_WIDTH  write data
rd_req  in  NUM_CH  consumer intake request
blk_en  out  1  fast-side block enable
wr_tick  out  1  write-tick pulse; one cycle high per DIV_RATIO cycles
wr_ready  out  NUM_CH  registered producer backpressure
rd_data  out  NUM_CH x DATA_WIDTH  head entry (first-word-fall-through)
fifo_empty  out  NUM_CH  occupancy == 0
fifo_count  out  NUM_CH x (log2(DEPTH)+1)  occupancy
overflow_err  out  NUM_CH  sticky overflow flag

Behaviour:
- Reset values: tick counter 0, all pointers and counts 0, fifo_empty all 1, wr_ready all 1, overflow_err all 0, wr_tick 0. Reset has priority over every other input.
- Tick generation:
  - Counter runs 0..DIV_RATIO-1 and wraps.
  - wr_tick = 1 when the counter is DIV_RATIO-1, so the first tick comes DIV_RATIO cycles after reset deasserts.
  - DIV_RATIO=1 holds wr_tick at 1.
- Write: wr_fire[i] = wr_tick & mode==WORK & wr_en[i] & (count[i] < DEPTH).
  - Write tick while full (count[i]==DEPTH) and wr_en[i]: data is dropped and overflow_err[i] is set. It stays set until rst or flush[i].
- Halt: halt[i] = mode==WORK & rd_req[i] & fifo_empty[i].
- blk_en = mode==WORK & unit_en & ~|halt & out_q_wr_ready.
- Read: rd_fire[i] = blk_en & rd_req[i] & ~fifo_empty[i].
  - rd_data[i] = mem[i][rd_ptr[i]] combinationally; it is undefined while empty.
- Count update: wr_fire & rd_fire leaves the count unchanged; wr_fire alone gives +1; rd_fire alone gives -1. Pointers wrap modulo DEPTH.
- Write to an empty FIFO: the entry becomes visible the next cycle. There is no same-cycle bypass.
- wr_ready[i] is registered on every cycle as (count_next[i] < DEPTH-AF_MARGIN), so it is valid for the next tick.
  - AF_MARGIN=0: wr_ready means not full.
- flush[i]: at the next edge, rd_ptr, wr_ptr and count for channel i go to 0, overflow_err[i] clears, and wr_ready[i] is set to 1.
  - flush[i] overrides any simultaneous wr_fire/rd_fire on that channel only.
  - Other channels are unaffected, and the tick counter is not reset.
- mode≠WORK: no writes, no halts, and blk_en=0. Stored contents and counts are held.
- Reset mid-operation: all contents are discarded. Memory contents need not clear; only pointers and counts are reset.

Decomposition:
- Shared package holds MODE_WORK/MODE_LOAD, clog2-derived width localparams and a data-entry typedef.
- One natural sub-module, fifo_ch_mem: single channel, DEPTH x DATA_WIDTH, synchronous write and asynchronous read. It is instantiated NUM_CH times in a generate loop.
- Tick counter, control logic and counters stay in the top level.

Test Plan:
1. Reset, then 12 idle cycles (defaults) -> wr_tick high on cycles 4, 8, 12; fifo_empty=4'hF, wr_ready=4'hF, fifo_count all 0, overflow_err=0.
2. ch0 wr_en held, data 0x10, 0x11, …; no reads -> count reaches 8 after 8 ticks; wr_ready[0] falls once count ≥7; 9th tick sets overflow_err[0]; count stays 8.
3. ch1 holds 1 entry (0xA5), rd_req=4'b0010, unit_en=1, out_q_wr_ready=1 -> blk_en=1, rd_data[1]=0xA5, count→0. Next cycle halt[1] forces blk_en=0.
4. ch2 count=3; rd_fire and wr_fire coincide on a tick -> count stays 3; written data is read out after the 2 older entries.
5. ch0 full with overflow_err=1; pulse flush[0] while ch3 writes on a tick -> ch0 count=0, overflow_err[0]=0, wr_ready[0]=1; ch3 count increments normally.
6. mode=LOAD with wr_en=4'hF over 3 ticks -> no count change, blk_en=0. Return to WORK and read -> pre-existing data is intact.
